// File: rtl/me_pkg.sv
// Shared types and constants for the motion-estimation scan controller.
package me_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_CUR  = 3'd1,
    ST_LOAD_SRCH = 3'd2,
    ST_SCAN      = 3'd3,
    ST_SHIFT     = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  localparam logic [1:0] SEL_DOWN = 2'd0;
  localparam logic [1:0] SEL_UP   = 2'd1;
  localparam logic [1:0] SEL_LEFT = 2'd2;

  localparam int unsigned MACRO_DIM_DEF = 16;
  localparam int unsigned SEARCH_W_DEF  = 48;
  localparam int unsigned SEARCH_H_DEF  = 48;
  localparam int unsigned SAD_W_DEF     = 16;

  // Handshake and datapath-enable bundle driven by the controller.
  typedef struct packed {
    logic       readyi;
    logic       valido;
    logic       en_cpr;
    logic       en_spr;
    logic       en_ram;
    logic       comp_en;
    logic [1:0] sel;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{readyi: 1'b1, valido: 1'b0, en_cpr: 1'b0, en_spr: 1'b0,
                                  en_ram: 1'b0, comp_en: 1'b0, sel: SEL_DOWN};

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/me_best_tracker.sv
// Keeps the lowest SAD seen so far and the displacement where it occurred.
module me_best_tracker #(
  parameter int unsigned SAD_W = 16,
  parameter int unsigned AW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             force_upd,
  input  logic [SAD_W-1:0] sad_in,
  input  logic [AW-1:0]    col,
  input  logic [AW-1:0]    row,
  output logic [SAD_W-1:0] best_sad,
  output logic [AW-1:0]    mv_x,
  output logic [AW-1:0]    mv_y
);

  // Strict less-than so that ties keep the earlier candidate in scan order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_sad <= '1;
      mv_x     <= '0;
      mv_y     <= '0;
    end else if (clr) begin
      best_sad <= '1;
      mv_x     <= '0;
      mv_y     <= '0;
    end else if (en && (force_upd || (sad_in < best_sad))) begin
      best_sad <= sad_in;
      mv_x     <= col;
      mv_y     <= row;
    end
  end

endmodule

// File: rtl/me_scan_ctrl.sv
// Full-search block-matching controller: loads blocks, snakes through candidates, tracks best SAD.
// Optional early termination on SAD threshold when ME_EARLY_TERM_EN is defined.
module me_scan_ctrl
  import me_pkg::*;
#(
  parameter int unsigned MACRO_DIM = MACRO_DIM_DEF,
  parameter int unsigned SEARCH_W  = SEARCH_W_DEF,
  parameter int unsigned SEARCH_H  = SEARCH_H_DEF,
  parameter int unsigned SAD_W     = SAD_W_DEF,
  localparam int unsigned AW       = $clog2(max_u(SEARCH_W, SEARCH_H))
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             readyi,
  output logic             valido,
  input  logic             readyo,
  output logic             en_cpr,
  output logic             en_spr,
  output logic             en_ram,
  output logic             comp_en,
  output logic [1:0]       sel,
  output logic [AW-1:0]    addr,
  output logic [AW-1:0]    col,
  input  logic [SAD_W-1:0] sad_in,
`ifdef ME_EARLY_TERM_EN
  input  logic [SAD_W-1:0] sad_thresh,
`endif
  output logic [SAD_W-1:0] best_sad,
  output logic [AW-1:0]    mv_x,
  output logic [AW-1:0]    mv_y
);

  localparam int unsigned C  = SEARCH_W - MACRO_DIM + 1;
  localparam int unsigned R  = SEARCH_H - MACRO_DIM + 1;
  localparam int unsigned CW = $clog2(MACRO_DIM);

  localparam logic [CW-1:0] CNT_LAST = CW'(MACRO_DIM - 1);
  localparam logic [AW-1:0] ROW_LAST = AW'(R - 1);
  localparam logic [AW-1:0] COL_LAST = AW'(C - 1);
  localparam logic [AW-1:0] ROW_OFS  = AW'(MACRO_DIM);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] row_q, row_d;
  logic [AW-1:0] col_q, col_d;
  logic          dir_q, dir_d;
  ctrl_t         ctrl_q, ctrl_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          clr_c;
  logic          hit_c;
  logic          col_end_c;
  logic          last_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      dir_q   <= 1'b0;
      ctrl_q  <= CTRL_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      dir_q   <= dir_d;
      ctrl_q  <= ctrl_d;
      addr_q  <= addr_d;
    end
  end

  // Next state and counters, then outputs decoded from the next state so they come out registered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    col_d     = col_q;
    dir_d     = dir_q;
    clr_c     = 1'b0;
    hit_c     = 1'b0;
    last_c    = 1'b0;
    ctrl_d    = '0;
    addr_d    = '0;
`ifdef ME_EARLY_TERM_EN
    hit_c = (state_q == ST_SCAN) && ctrl_q.comp_en && (sad_in <= sad_thresh);
`endif
    col_end_c = dir_q ? (row_q == '0) : (row_q == ROW_LAST);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD_CUR;
          cnt_d   = '0;
          row_d   = '0;
          col_d   = '0;
          dir_d   = 1'b0;
          clr_c   = 1'b1;
        end
      end
      ST_LOAD_CUR: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_LOAD_SRCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_LOAD_SRCH: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
          row_d   = '0;
          col_d   = '0;
          dir_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SCAN: begin
        if (hit_c) begin
          state_d = ST_DONE;
        end else if (col_end_c) begin
          state_d = (col_q == COL_LAST) ? ST_DONE : ST_SHIFT;
        end else begin
          row_d = dir_q ? (row_q - AW'(1)) : (row_q + AW'(1));
        end
      end
      ST_SHIFT: begin
        state_d = ST_SCAN;
        col_d   = col_q + AW'(1);
        dir_d   = ~dir_q;
      end
      ST_DONE: begin
        if (readyo) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        row_d   = '0;
        col_d   = '0;
        dir_d   = 1'b0;
      end
    endcase

    case (state_d)
      ST_IDLE: ctrl_d.readyi = 1'b1;
      ST_LOAD_CUR: begin
        ctrl_d.en_cpr = 1'b1;
        ctrl_d.en_ram = 1'b1;
        ctrl_d.sel    = SEL_UP;
        addr_d        = AW'(cnt_d);
      end
      ST_LOAD_SRCH: begin
        ctrl_d.en_spr = 1'b1;
        ctrl_d.en_ram = 1'b1;
        ctrl_d.sel    = SEL_UP;
        addr_d        = AW'(cnt_d);
      end
      ST_SCAN: begin
        // The last row of a column needs no new search row; the next move is a shift.
        last_c         = dir_d ? (row_d == '0) : (row_d == ROW_LAST);
        ctrl_d.comp_en = 1'b1;
        ctrl_d.sel     = dir_d ? SEL_UP : SEL_DOWN;
        if (!last_c) begin
          ctrl_d.en_spr = 1'b1;
          ctrl_d.en_ram = 1'b1;
          addr_d        = dir_d ? (row_d - AW'(1)) : (row_d + ROW_OFS);
        end
      end
      ST_SHIFT: begin
        ctrl_d.en_spr = 1'b1;
        ctrl_d.sel    = SEL_LEFT;
      end
      ST_DONE: ctrl_d.valido = 1'b1;
      default: ctrl_d.readyi = 1'b1;
    endcase
  end

  me_best_tracker #(
    .SAD_W(SAD_W),
    .AW   (AW)
  ) u_best (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr_c),
    .en       (ctrl_q.comp_en),
    .force_upd(hit_c),
    .sad_in   (sad_in),
    .col      (col_q),
    .row      (row_q),
    .best_sad (best_sad),
    .mv_x     (mv_x),
    .mv_y     (mv_y)
  );

  assign readyi  = ctrl_q.readyi;
  assign valido  = ctrl_q.valido;
  assign en_cpr  = ctrl_q.en_cpr;
  assign en_spr  = ctrl_q.en_spr;
  assign en_ram  = ctrl_q.en_ram;
  assign comp_en = ctrl_q.comp_en;
  assign sel     = ctrl_q.sel;
  assign addr    = addr_q;
  assign col     = col_q;

endmodule
